// File: rtl/hit_normal_pipeline.sv
// Hit point and surface normal stage feeding the reflector.
// Six registered stages, Q16.16 arithmetic, no backpressure.
module hit_normal_pipeline #(
  parameter int LAT = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_data,
  input  logic [95:0] o,
  input  logic [95:0] d,
  input  logic [31:0] t,
  input  logic [95:0] c,
  input  logic [31:0] inv_r,
  input  logic        hit,
  output logic [95:0] p,
  output logic [95:0] v,
  output logic [95:0] n,
  output logic        hit_out,
  output logic        output_valid
);

  if (LAT != 6) begin : g_lat_bad
    $error("hit_normal_pipeline: LAT is fixed at 6");
  end

  function automatic logic [31:0] qmul(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    logic signed [63:0] pr;
    pr = 64'(a) * 64'(b);
    return 32'(pr >>> 16);
  endfunction

  function automatic logic [95:0] vscale(
    input logic [95:0] a,
    input logic [31:0] s
  );
    return {qmul(a[95:64], s),
            qmul(a[63:32], s),
            qmul(a[31:0], s)};
  endfunction

  function automatic logic [95:0] vadd(
    input logic [95:0] a,
    input logic [95:0] b
  );
    return {a[95:64] + b[95:64],
            a[63:32] + b[63:32],
            a[31:0] + b[31:0]};
  endfunction

  function automatic logic [95:0] vsub(
    input logic [95:0] a,
    input logic [95:0] b
  );
    return {a[95:64] - b[95:64],
            a[63:32] - b[63:32],
            a[31:0] - b[31:0]};
  endfunction

  logic        v1, h1;
  logic [95:0] o1, d1, c1;
  logic [31:0] t1, r1;

  logic        v2, h2;
  logic [95:0] o2, d2, td2, c2;
  logic [31:0] r2;

  logic        v3, h3;
  logic [95:0] d3, p3, c3;
  logic [31:0] r3;

  logic        v4, h4;
  logic [95:0] d4, p4, df4;
  logic [31:0] r4;

  logic        v5, h5;
  logic [95:0] d5, p5, n5;

  // S1: capture the incoming item
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      h1 <= 1'b0;
      o1 <= '0;
      d1 <= '0;
      c1 <= '0;
      t1 <= '0;
      r1 <= '0;
    end else begin
      v1 <= new_data;
      h1 <= hit;
      o1 <= o;
      d1 <= d;
      c1 <= c;
      t1 <= t;
      r1 <= inv_r;
    end
  end

  // S2: scale the direction by the hit distance
  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      h2  <= 1'b0;
      o2  <= '0;
      d2  <= '0;
      td2 <= '0;
      c2  <= '0;
      r2  <= '0;
    end else begin
      v2  <= v1;
      h2  <= h1;
      o2  <= o1;
      d2  <= d1;
      td2 <= vscale(d1, t1);
      c2  <= c1;
      r2  <= r1;
    end
  end

  // S3: hit point; a miss leaves the point at the origin
  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0;
      h3 <= 1'b0;
      d3 <= '0;
      p3 <= '0;
      c3 <= '0;
      r3 <= '0;
    end else begin
      v3 <= v2;
      h3 <= h2;
      d3 <= d2;
      p3 <= vadd(o2, h2 ? td2 : 96'd0);
      c3 <= c2;
      r3 <= r2;
    end
  end

  // S4: offset of the hit point from the sphere centre
  always_ff @(posedge clk) begin
    if (rst) begin
      v4  <= 1'b0;
      h4  <= 1'b0;
      d4  <= '0;
      p4  <= '0;
      df4 <= '0;
      r4  <= '0;
    end else begin
      v4  <= v3;
      h4  <= h3;
      d4  <= d3;
      p4  <= p3;
      df4 <= vsub(p3, c3);
      r4  <= r3;
    end
  end

  // S5: normalise by the reciprocal radius; misses give a zero normal
  always_ff @(posedge clk) begin
    if (rst) begin
      v5 <= 1'b0;
      h5 <= 1'b0;
      d5 <= '0;
      p5 <= '0;
      n5 <= '0;
    end else begin
      v5 <= v4;
      h5 <= h4;
      d5 <= d4;
      p5 <= p4;
      n5 <= h4 ? vscale(df4, r4) : 96'd0;
    end
  end

  // S6: output register, data held at zero in empty slots
  always_ff @(posedge clk) begin
    if (rst) begin
      output_valid <= 1'b0;
      hit_out      <= 1'b0;
      p            <= '0;
      v            <= '0;
      n            <= '0;
    end else begin
      output_valid <= v5;
      hit_out      <= v5 & h5;
      p            <= v5 ? p5 : 96'd0;
      v            <= v5 ? d5 : 96'd0;
      n            <= v5 ? n5 : 96'd0;
    end
  end

endmodule

// File: tb/tb_hit_normal_pipeline.sv
// Directed and streaming checks for hit_normal_pipeline.
// Expected values are hand constants or a Q16.16 reference model.
module tb_hit_normal_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_data = 1'b0;
  logic [95:0] o = '0, d = '0, c = '0;
  logic [31:0] t = '0, inv_r = '0;
  logic        hit = 1'b0;
  logic [95:0] p, v, n;
  logic        hit_out, output_valid;

  hit_normal_pipeline dut (
    .clk(clk), .rst(rst), .new_data(new_data),
    .o(o), .d(d), .t(t), .c(c), .inv_r(inv_r),
    .hit(hit), .p(p), .v(v), .n(n),
    .hit_out(hit_out), .output_valid(output_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic        e_v[0:1023];
  logic        e_z[0:1023];
  logic        e_h[0:1023];
  logic [95:0] e_p[0:1023];
  logic [95:0] e_d[0:1023];
  logic [95:0] e_n[0:1023];

  task automatic chk(input string tag,
                     input logic [95:0] got,
                     input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0d: got %h want %h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] fm(input logic signed [31:0] a,
                                      input logic signed [31:0] b);
    longint pr;
    pr = longint'(a) * longint'(b);
    pr = pr >>> 16;
    return pr[31:0];
  endfunction

  function automatic logic [95:0] mp(input logic hh,
                                     input logic [95:0] oo, dd,
                                     input logic [31:0] tt);
    logic [95:0] r;
    for (int i = 0; i < 3; i++)
      r[i*32 +: 32] = oo[i*32 +: 32] +
                      (hh ? fm(dd[i*32 +: 32], tt) : 32'd0);
    return r;
  endfunction

  function automatic logic [95:0] mn(input logic hh,
                                     input logic [95:0] pp, cc,
                                     input logic [31:0] rr);
    logic [95:0] r;
    for (int i = 0; i < 3; i++)
      r[i*32 +: 32] = hh ?
        fm(pp[i*32 +: 32] - cc[i*32 +: 32], rr) : 32'd0;
    return r;
  endfunction

  task automatic step(input logic nd, input logic hh,
                      input logic [95:0] oo, dd,
                      input logic [31:0] tt,
                      input logic [95:0] cc,
                      input logic [31:0] rr,
                      input logic rs,
                      input logic [95:0] ep, en);
    int k;
    @(negedge clk);
    if (cyc >= 6) begin
      k = cyc - 6;
      chk("valid", {95'd0, output_valid}, {95'd0, e_v[k]});
      if (e_v[k]) begin
        chk("p", p, e_p[k]);
        chk("v", v, e_d[k]);
        chk("n", n, e_n[k]);
        chk("hit_out", {95'd0, hit_out}, {95'd0, e_h[k]});
      end else if (e_z[k]) begin
        chk("p_zero", p, 96'd0);
        chk("v_zero", v, 96'd0);
        chk("n_zero", n, 96'd0);
        chk("hit_zero", {95'd0, hit_out}, 96'd0);
      end
    end
    new_data = nd;
    hit = hh;
    o = oo;
    d = dd;
    t = tt;
    c = cc;
    inv_r = rr;
    rst = rs;
    e_v[cyc] = nd & ~rs;
    e_z[cyc] = 1'b0;
    e_h[cyc] = hh;
    e_p[cyc] = ep;
    e_d[cyc] = dd;
    e_n[cyc] = en;
    if (rs)
      for (int j = cyc - 5; j <= cyc; j++)
        if (j >= 0) begin
          e_v[j] = 1'b0;
          e_z[j] = 1'b1;
        end
    cyc++;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++)
      step(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic rnd(input logic nd);
    logic [95:0] oo, dd, cc, pp;
    logic [31:0] tt, rr;
    logic hh;
    oo = {$urandom, $urandom, $urandom};
    dd = {$urandom, $urandom, $urandom};
    cc = {$urandom, $urandom, $urandom};
    tt = $urandom;
    rr = $urandom;
    hh = 1'($urandom_range(0, 3) != 0);
    pp = mp(hh, oo, dd, tt);
    step(nd, hh, oo, dd, tt, cc, rr, 1'b0, pp, mn(hh, pp, cc, rr));
  endtask

  logic [4:0] gaps;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      e_v[i] = 1'b0;
      e_z[i] = 1'b0;
      e_h[i] = 1'b0;
      e_p[i] = '0;
      e_d[i] = '0;
      e_n[i] = '0;
    end
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 96'h1, 96'h2, 32'h3, '0, '0, 1'b1, '0, '0);
    idle(2);
    chk("rst_valid", {95'd0, output_valid}, 96'd0);
    chk("rst_p", p, 96'd0);
    chk("rst_n", n, 96'd0);

    step(1'b1, 1'b1, 96'd0, {32'h00010000, 64'd0}, 32'h00020000,
         {32'h00030000, 64'd0}, 32'h00010000, 1'b0,
         {32'h00020000, 64'd0}, {32'hFFFF0000, 64'd0});
    idle(2);
    step(1'b1, 1'b1, {32'd0, 32'h00010000, 32'd0},
         {32'd0, 32'h00008000, 32'd0}, 32'h00030000,
         96'd0, 32'h00008000, 1'b0,
         {32'd0, 32'h00028000, 32'd0},
         {32'd0, 32'h00014000, 32'd0});
    step(1'b1, 1'b1, 96'd0, {32'h00008000, 64'd0}, 32'hFFFFFFFF,
         96'd0, 32'h00010000, 1'b0,
         {32'hFFFFFFFF, 64'd0}, {32'hFFFFFFFF, 64'd0});
    step(1'b1, 1'b0,
         {32'h00010000, 32'h00020000, 32'h00030000},
         {32'h00010000, 32'h00010000, 32'h00010000},
         32'h00050000, 96'd0, 32'h00010000, 1'b0,
         {32'h00010000, 32'h00020000, 32'h00030000}, 96'd0);
    step(1'b1, 1'b1, {32'h7FFF0000, 64'd0},
         {32'h00010000, 64'd0}, 32'h00020000,
         96'd0, 32'h00000000, 1'b0,
         {32'h80010000, 64'd0}, 96'd0);
    idle(7);

    for (int i = 0; i < 20; i++) rnd(1'b1);
    gaps = 5'b10110;
    for (int i = 4; i >= 0; i--) rnd(gaps[i]);
    idle(8);

    rnd(1'b1);
    rnd(1'b1);
    step(1'b1, 1'b1, 96'h5, 96'h6, 32'h7, '0, '0, 1'b1, '0, '0);
    idle(3);
    step(1'b1, 1'b1, 96'd0, {32'h00010000, 64'd0}, 32'h00020000,
         {32'h00030000, 64'd0}, 32'h00010000, 1'b0,
         {32'h00020000, 64'd0}, {32'hFFFF0000, 64'd0});
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
